// File: rtl/pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// PipeClaAdder: two-stage pipelined carry-lookahead adder/subtractor.
//
// Stage 1 adds the low WIDTH/2 bits with 4-bit group generate/propagate
// lookahead. It registers the low sum, the carry into the upper half, the
// upper half of a, and the upper half of the effective b operand.
// Stage 2 adds the upper half with the same lookahead structure. It forms
// cout, ovfl and zero and registers them as the outputs.
// Valid/ready handshakes on both sides. Stage 2 advances whenever the output
// register is empty or is being consumed.
//
// Parameters
//   WIDTH      operand width, a multiple of 8, at least 8 (default 16)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   block accepts operands this cycle (combinational)
//   a, b       operands (two's complement or unsigned)
//   cin        carry-in, used only for addition
//   sub        0: a + b + cin, 1: a - b
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovfl       signed overflow
//   zero       sum == 0 (evaluated on the driven sum)
//
// Build option
//   PIPE_CLA_SAT_EN  when defined, a signed overflow replaces sum with the
//                    signed limit in the direction of a. ovfl and the raw
//                    cout are still reported.
// ---------------------------------------------------------------------------
module pipe_cla_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovfl,
   output logic             zero
);

   localparam int HALF = WIDTH / 2;
   localparam int NGRP = HALF / 4;

   // One 4-bit lookahead group.
   // Returns {groupGenerate, groupPropagate, sum[3:0]}. The in-group carries
   // are formed directly from the bit g/p terms, not rippled.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;
      logic       gg;
      logic       pg;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg   = &p;
      return {gg, pg, p ^ c};
   endfunction

   // Half-width adder built from 4-bit groups.
   // The carry into each group comes from the previous group's G/P pair.
   // Returns {carryOut, sum[HALF-1:0]}.
   function automatic logic [HALF:0] claHalf(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic             ci);
      logic [HALF-1:0] s;
      logic [NGRP:0]   gc;
      logic [5:0]      grpRes;
      s     = '0;
      gc    = '0;
      gc[0] = ci;
      for (int grp = 0; grp < NGRP; grp++) begin
         grpRes         = cla4(x[grp*4 +: 4], y[grp*4 +: 4], gc[grp]);
         s[grp*4 +: 4]  = grpRes[3:0];
         gc[grp+1]      = grpRes[5] | (grpRes[4] & gc[grp]);
      end
      return {gc[NGRP], s};
   endfunction

   // ------------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------------
   logic            s1Valid_q,  s1Valid_d;
   logic [HALF-1:0] s1LoSum_q,  s1LoSum_d;
   logic            s1Carry_q,  s1Carry_d;
   logic [HALF-1:0] s1AHi_q,    s1AHi_d;
   logic [HALF-1:0] s1BHi_q,    s1BHi_d;

   logic             outValid_q, outValid_d;
   logic [WIDTH-1:0] sum_q,      sum_d;
   logic             cout_q,     cout_d;
   logic             ovfl_q,     ovfl_d;
   logic             zero_q,     zero_d;

   // ------------------------------------------------------------------------
   // Handshake control
   // ------------------------------------------------------------------------
   logic advance2;
   logic accept;

   // Stage 2 may load whenever its current result is absent or leaving.
   // Stage 1 may load whenever it is empty or its content moves into stage 2.
   // in_ready therefore depends only on state and out_ready, never in_valid.
   assign advance2 = !outValid_q || out_ready;
   assign in_ready = !s1Valid_q || advance2;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------------------
   // Stage 1 datapath: effective operand and low-half add
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] bEff;
   logic             cEff;
   logic [HALF:0]    loRes;

   // Subtraction is a + ~b + 1, so the carry-in is forced high and cin is
   // ignored.
   assign bEff  = sub ? ~b : b;
   assign cEff  = sub ? 1'b1 : cin;
   assign loRes = claHalf(a[HALF-1:0], bEff[HALF-1:0], cEff);

   // Stage 1 next state.
   // Operand data is only captured on an accepted transfer, so inputs
   // presented without a handshake never reach the pipeline.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1LoSum_d = s1LoSum_q;
      s1Carry_d = s1Carry_q;
      s1AHi_d   = s1AHi_q;
      s1BHi_d   = s1BHi_q;
      if (in_ready) begin
         s1Valid_d = in_valid;
      end
      if (accept) begin
         s1LoSum_d = loRes[HALF-1:0];
         s1Carry_d = loRes[HALF];
         s1AHi_d   = a[WIDTH-1:HALF];
         s1BHi_d   = bEff[WIDTH-1:HALF];
      end
   end

   // Stage 1 register.
   // Reset clears valid so an in-flight operation is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1LoSum_q <= '0;
         s1Carry_q <= 1'b0;
         s1AHi_q   <= '0;
         s1BHi_q   <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1LoSum_q <= s1LoSum_d;
         s1Carry_q <= s1Carry_d;
         s1AHi_q   <= s1AHi_d;
         s1BHi_q   <= s1BHi_d;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2 datapath: upper-half add, flags, optional saturation
   // ------------------------------------------------------------------------
   logic [HALF:0]    hiRes;
   logic [WIDTH-1:0] rawSum;
   logic             rawOvfl;
   logic             aMsb;
   logic [WIDTH-1:0] finalSum;

   assign hiRes  = claHalf(s1AHi_q, s1BHi_q, s1Carry_q);
   assign rawSum = {hiRes[HALF-1:0], s1LoSum_q};
   assign aMsb   = s1AHi_q[HALF-1];

   // Signed overflow: both operands have the same sign and the raw result
   // has the other sign.
   assign rawOvfl = (aMsb == s1BHi_q[HALF-1]) && (rawSum[WIDTH-1] != aMsb);

`ifdef PIPE_CLA_SAT_EN
   // Clamp to the signed limit on the side of a: 0x7F..F for positive a,
   // 0x80..0 for negative a.
   assign finalSum = rawOvfl ? {aMsb, {(WIDTH-1){~aMsb}}} : rawSum;
`else
   assign finalSum = rawSum;
`endif

   // Stage 2 next state.
   // When stage 2 advances with stage 1 empty, the output goes invalid. The
   // data fields keep their last values because out_valid qualifies them.
   always_comb begin
      outValid_d = outValid_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      ovfl_d     = ovfl_q;
      zero_d     = zero_q;
      if (advance2) begin
         outValid_d = s1Valid_q;
         if (s1Valid_q) begin
            sum_d  = finalSum;
            cout_d = hiRes[HALF];
            ovfl_d = rawOvfl;
            zero_d = (finalSum == '0);
         end
      end
   end

   // Stage 2 / output register.
   // Reset clears it immediately while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovfl_q     <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         outValid_q <= outValid_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         ovfl_q     <= ovfl_d;
         zero_q     <= zero_d;
      end
   end

   assign out_valid = outValid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovfl      = ovfl_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// TbPipeClaAdder: directed and randomized checks of pipe_cla_adder at
// WIDTH=16. The directed steps cover overflow, carry across the half
// boundary, subtraction, a stall with both stages full, and a reset with
// operations in flight. The final step streams 100 random operations
// against an arithmetic reference model.
// Expected results are packed as {sum[15:0], cout, ovfl, zero}.
// ---------------------------------------------------------------------------
module tb_pipe_cla_adder;

   localparam int W = 16;

`ifdef PIPE_CLA_SAT_EN
   localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
   localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
`else
   localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
   localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovfl;
   logic         zero;

   int checks = 0;
   int errors = 0;

   logic [18:0] expQ[$];

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   pipe_cla_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovfl      (ovfl),
      .zero      (zero)
   );

   // Arithmetic reference, written from the operation definition rather
   // than any adder structure
   function automatic logic [18:0] refModel(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
      logic [15:0] be;
      logic [16:0] full;
      logic [15:0] res;
      logic        ov;
      be   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, be} + {16'b0, (s ? 1'b1 : c)};
      ov   = (x[15] == be[15]) && (full[15] != x[15]);
      res  = full[15:0];
`ifdef PIPE_CLA_SAT_EN
      if (ov) res = x[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {res, full[16], ov, (res == 16'h0000)};
   endfunction

   // Drive one set of input values
   task automatic applyStimulus(input logic v, input logic [15:0] va, input logic [15:0] vb,
                                input logic vc, input logic vs);
      in_valid = v;
      a        = va;
      b        = vb;
      cin      = vc;
      sub      = vs;
   endtask

   // One counted comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Single operation through an otherwise idle pipeline.
   // The inputs are scrambled after acceptance, so any capture of
   // unaccepted operands would corrupt the result.
   task automatic runDirected(input string tag, input logic [15:0] va, input logic [15:0] vb,
                              input logic vc, input logic vs, input logic [18:0] expected);
      @(negedge clk);
      applyStimulus(1'b1, va, vb, vc, vs);
      #1 checkOutput({tag, "_inReady"}, {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(1'b0, ~va, va ^ vb, ~vc, ~vs);
      #1 checkOutput({tag, "_notYet"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      #1 checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, "_result"}, {13'b0, sum, cout, ovfl, zero}, {13'b0, expected});
   endtask

   // Watchdog: the sequence is fixed length, so this only fires if the
   // simulation stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence
   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic        rs;
      logic [18:0] expHead;

      // Reset state while rst_n is held low
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1 checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
      checkOutput("rstResult", {13'b0, sum, cout, ovfl, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("relInReady", {31'b0, in_ready}, 32'd1);

      // Directed arithmetic
      runDirected("addOvf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {EXP_ADD_OVF, 1'b0, 1'b1, 1'b0});
      runDirected("addWrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
      runDirected("subNeg",   16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
      runDirected("subOvf",   16'h8000, 16'h0001, 1'b0, 1'b1, {EXP_SUB_OVF, 1'b1, 1'b1, 1'b0});
      runDirected("addCin",   16'h1234, 16'h0FCB, 1'b1, 1'b0, {16'h2200, 1'b0, 1'b0, 1'b0});
      runDirected("subCinIg", 16'h0010, 16'h0010, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
      runDirected("loCarry",  16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0});

      // Stall: three back-to-back ops, consumer blocks for two cycles
      out_ready = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
      #1 checkOutput("stallAccA", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0);
      #1 checkOutput("stallAccB", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0009, 16'h0004, 1'b0, 1'b1);
      #1 checkOutput("stallValid0", {31'b0, out_valid}, 32'd1);
      checkOutput("stallHeld0", {13'b0, sum, cout, ovfl, zero}, {13'b0, 16'h0003, 3'b000});
      checkOutput("stallFull0", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      #1 checkOutput("stallValid1", {31'b0, out_valid}, 32'd1);
      checkOutput("stallHeld1", {13'b0, sum, cout, ovfl, zero}, {13'b0, 16'h0003, 3'b000});
      checkOutput("stallFull1", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      #1 checkOutput("stallResume", {31'b0, in_ready}, 32'd1);
      checkOutput("stallHeld2", {13'b0, sum, cout, ovfl, zero}, {13'b0, 16'h0003, 3'b000});
      @(negedge clk);
      applyStimulus(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
      #1 checkOutput("stallValidB", {31'b0, out_valid}, 32'd1);
      checkOutput("stallResB", {13'b0, sum, cout, ovfl, zero}, {13'b0, 16'h0300, 3'b000});
      @(negedge clk);
      #1 checkOutput("stallValidC", {31'b0, out_valid}, 32'd1);
      checkOutput("stallResC", {13'b0, sum, cout, ovfl, zero}, {13'b0, 16'h0005, 3'b100});
      @(negedge clk);
      #1 checkOutput("stallDrained", {31'b0, out_valid}, 32'd0);

      // Reset with two operations in flight
      @(negedge clk);
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1 checkOutput("preRstValid", {31'b0, out_valid}, 32'd1);
      checkOutput("preRstSum", {16'b0, sum}, {16'b0, 16'h3333});
      rst_n = 1'b0;
      #1 checkOutput("midRstValid", {31'b0, out_valid}, 32'd0);
      checkOutput("midRstResult", {13'b0, sum, cout, ovfl, zero}, 32'd0);
      @(negedge clk);
      #1 checkOutput("midRstHold", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b1;
      #1 checkOutput("postRstReady", {31'b0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 checkOutput("postRstQuiet", {31'b0, out_valid}, 32'd0);
      end

      // Continuous streaming of 100 random operations
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 102; cyc++) begin
         @(negedge clk);
         #1;
         if (cyc == 1) begin
            checkOutput("streamFill", {31'b0, out_valid}, 32'd0);
         end
         if (cyc >= 2) begin
            checkOutput("streamValid", {31'b0, out_valid}, 32'd1);
            if (expQ.size() > 0) begin
               expHead = expQ.pop_front();
               checkOutput("streamResult", {13'b0, sum, cout, ovfl, zero}, {13'b0, expHead});
            end else begin
               checkOutput("streamUnderflow", 32'd0, 32'd1);
            end
         end
         if (cyc < 100) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            applyStimulus(1'b1, ra, rb, rc, rs);
            #1 checkOutput("streamReady", {31'b0, in_ready}, 32'd1);
            if (in_ready) expQ.push_back(refModel(ra, rb, rc, rs));
         end else begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
         end
      end
      @(negedge clk);
      #1 checkOutput("streamDrained", {31'b0, out_valid}, 32'd0);
      checkOutput("streamQueueEmpty", expQ.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
